dut_wrapper: RTL and testbench
==============================

DUT_WRAPPER -- requirements
Module: dut_wrapper

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter DUT_TYPE (string), default "adder_rca", giving the initial arithmetic function select.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port a, input, WIDTH bits: unsigned operand A.
REQ-006 The block SHALL have port b, input, WIDTH bits: unsigned operand B.
REQ-007 The block SHALL have port result, output, 2*WIDTH bits: registered unsigned result.
REQ-008 The block SHALL hold an internal string variable dut_type, initialised from DUT_TYPE, which a bench may override at run time (hierarchical force/assign); function selection SHALL always follow the current value of dut_type.

Function
REQ-009 For dut_type "adder_rca", the next result SHALL be {WIDTH zeros, (a+b) mod 2^WIDTH}, computed by a WIDTH-stage ripple-carry chain of full adders.
REQ-010 For dut_type "adder_cla", the next result SHALL be identical to REQ-009, computed by a carry-lookahead adder (per-bit generate/propagate, 4-bit lookahead groups, group carries rippled between groups).
REQ-011 In both adder modes the carry-out of bit WIDTH-1 SHALL be discarded, and result[2*WIDTH-1:WIDTH] SHALL be 0.
REQ-012 For dut_type "multiplier" or "mult", the next result SHALL be the full unsigned product a*b (2*WIDTH bits, no truncation), computed by a shift-and-add array of WIDTH partial-product rows.
REQ-013 For any other dut_type value, the next result SHALL be 0.
REQ-014 All three datapaths SHALL be purely combinational; only the selected datapath output SHALL be captured into the result register.
REQ-015 result SHALL be registered and SHALL update on every rising clk edge while reset is high (no enable, no handshake).
REQ-016 Latency SHALL be 1 cycle: inputs stable before rising edge N appear on result after edge N and hold until the next edge.
REQ-017 Changing dut_type mid-run SHALL take effect at the next rising clk edge, with no other side effects.
REQ-018 Boundary behaviour SHALL be: adder wrap-around (e.g. 255+1 -> 0 at WIDTH=8); multiplier maximum (2^WIDTH-1)^2 represented exactly; operand 0 gives sum = other operand and product 0.

Reset
REQ-019 When reset is low, result SHALL clear to 0 immediately, independent of clk.
REQ-020 While reset is low, result SHALL stay 0 regardless of a, b and dut_type.
REQ-021 After reset is released, result SHALL be loaded at the first rising clk edge; a reset asserted mid-operation SHALL discard the in-flight value.

Verification (WIDTH=8, results checked 2 clk edges after inputs are applied)
REQ-022 The bench SHALL cover adder_rca with a=5,b=3 -> 8; a=255,b=1 -> 0; a=128,b=128 -> 0; a=1,b=255 -> 0; a=127,b=129 -> 0.
REQ-023 The bench SHALL cover adder_cla with a=0,b=100 -> 100; a=15,b=2 -> 17; a=255,b=1 -> 0, and check that it matches adder_rca for the same operands.
REQ-024 The bench SHALL cover multiplier/mult with a=10,b=4 -> 40; a=255,b=255 -> 65025; a=127,b=129 -> 16383; a=0,b=100 -> 0.
REQ-025 The bench SHALL cover dut_type "foo" with a=5,b=3 -> result 0.
REQ-026 The bench SHALL cover reset: drive reset low between clk edges while result=40 -> result 0 immediately; release -> correct value after the next edge.
REQ-027 The bench SHALL cover exhaustive sweeps (a over 0..255 with b over 0..255, up to a vector limit) in all three modes against the reference equations, with zero failures.

Source files
------------

// File: rtl/dut_wrapper.sv
// Selectable arithmetic unit: ripple-carry adder, carry-lookahead adder or
// shift-and-add multiplier, chosen at run time by the dut_type string.
module dut_wrapper #(
    parameter int    WIDTH    = 8,
    parameter string DUT_TYPE = "adder_rca"
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result
);

    localparam int NG = (WIDTH + 3) / 4;
    localparam int PW = NG * 4;

    // Benches may overwrite this hierarchically; selection re-reads it every edge.
    string dut_type = DUT_TYPE;

    logic [2*WIDTH-1:0] r_result;

    // Ripple-carry chain
    logic [WIDTH:0]   w_rca_c;
    logic [WIDTH-1:0] w_rca_s;

    assign w_rca_c[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_rca
        assign w_rca_s[i]   = a[i] ^ b[i] ^ w_rca_c[i];
        assign w_rca_c[i+1] = (a[i] & b[i]) | (w_rca_c[i] & (a[i] ^ b[i]));
    end

    // Carry-lookahead: 4-bit groups with full lookahead, group carries rippled
    logic [PW-1:0] w_pa, w_pb, w_g, w_p, w_c, w_cla_s;
    logic [NG:0]   w_gc;

    assign w_pa    = PW'(a);
    assign w_pb    = PW'(b);
    assign w_g     = w_pa & w_pb;
    assign w_p     = w_pa ^ w_pb;
    assign w_gc[0] = 1'b0;

    for (genvar gi = 0; gi < NG; gi++) begin : g_cla
        localparam int B = gi * 4;
        assign w_c[B]   = w_gc[gi];
        assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[gi]);
        assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                        | (w_p[B+1] & w_p[B] & w_gc[gi]);
        assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                        | (w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[gi]);
        assign w_gc[gi+1] = w_g[B+3] | (w_p[B+3] & w_g[B+2])
                          | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                          | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                          | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[gi]);
    end

    assign w_cla_s = w_p ^ w_c;

    // Shift-and-add: row i adds a<<i when b[i] is set
    logic [WIDTH:0][2*WIDTH-1:0] w_acc;

    assign w_acc[0] = '0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_mul
        assign w_acc[i+1] = w_acc[i] + (b[i] ? ((2*WIDTH)'(a) << i) : '0);
    end

    // Adder carry-outs and padding sum bits are dropped by design
    logic w_unused_bits;
    assign w_unused_bits = ^{w_rca_c[WIDTH], w_gc[NG], w_cla_s};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result <= '0;
        end else if (dut_type == "adder_rca") begin
            r_result <= (2*WIDTH)'(w_rca_s);
        end else if (dut_type == "adder_cla") begin
            r_result <= (2*WIDTH)'(w_cla_s[WIDTH-1:0]);
        end else if (dut_type == "multiplier" || dut_type == "mult") begin
            r_result <= w_acc[WIDTH];
        end else begin
            r_result <= '0;
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_dut_wrapper.sv
// Scoreboard bench for dut_wrapper at WIDTH=8: directed vectors, reset
// behaviour and strided operand sweeps in every mode.
module tb_dut_wrapper;
    localparam int W = 8;

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic [W-1:0]   a     = '0;
    logic [W-1:0]   b     = '0;
    logic [2*W-1:0] result;
    logic           stim_vld = 1'b0;

    typedef struct {
        logic [2*W-1:0] exp;
        string          tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    dut_wrapper #(.WIDTH(W), .DUT_TYPE("adder_rca")) dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*W-1:0] act,
                         input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Monitor: a vector presented before an edge is compared just after it
    initial begin : monitor
        logic v;
        exp_t e;
        forever begin
            @(posedge clk);
            v = stim_vld;
            #1;
            if (v) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got %0d expected none", result);
                end else begin
                    e = sb.pop_front();
                    check(e.tag, result, e.exp);
                end
            end
        end
    end

    task automatic apply(input string mode, input int av, input int bv,
                         input int exp, input string tag);
        exp_t e;
        @(negedge clk);
        dut.dut_type = mode;
        a        = W'(av);
        b        = W'(bv);
        stim_vld = 1'b1;
        e.exp    = (2*W)'(exp);
        e.tag    = tag;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        stim_vld = 1'b0;
    endtask

    initial begin
        #12;
        check("reset_state", result, 0);
        @(negedge clk);
        reset = 1'b1;

        apply("adder_rca", 5,   3,   8, "rca_5_3");
        apply("adder_rca", 255, 1,   0, "rca_255_1");
        apply("adder_rca", 128, 128, 0, "rca_128_128");
        apply("adder_rca", 1,   255, 0, "rca_1_255");
        apply("adder_rca", 127, 129, 0, "rca_127_129");
        apply("adder_rca", 0,   100, 100, "rca_0_100");
        apply("adder_rca", 15,  2,   17, "rca_15_2");

        apply("adder_cla", 0,   100, 100, "cla_0_100");
        apply("adder_cla", 15,  2,   17, "cla_15_2");
        apply("adder_cla", 255, 1,   0, "cla_255_1");
        apply("adder_cla", 200, 100, 44, "cla_200_100");

        apply("multiplier", 10,  4,   40, "mul_10_4");
        apply("mult",       255, 255, 65025, "mul_255_255");
        apply("multiplier", 127, 129, 16383, "mul_127_129");
        apply("mult",       0,   100, 0, "mul_0_100");

        apply("foo", 5, 3, 0, "foo_5_3");
        apply("adder_rca", 5, 3, 8, "rca_after_foo");

        // Reset between edges while result holds 40
        apply("mult", 10, 4, 40, "rst_pre");
        idle();
        #2 reset = 1'b0;
        #1 check("rst_immediate", result, 0);
        a = 8'd200;
        @(posedge clk);
        #1 check("rst_hold", result, 0);
        @(negedge clk);
        begin
            exp_t e;
            reset    = 1'b1;
            a        = 8'd10;
            b        = 8'd4;
            stim_vld = 1'b1;
            e.exp    = 16'd40;
            e.tag    = "rst_release";
            sb.push_back(e);
        end

        for (int av = 0; av < 256; av++) begin
            for (int bv = 0; bv < 256; bv += 17) begin
                apply("adder_rca", av, bv, (av + bv) % 256, "sweep_rca");
                apply("adder_cla", av, bv, (av + bv) % 256, "sweep_cla");
                apply("mult",      av, bv, av * bv, "sweep_mul");
            end
            apply("adder_cla", av, 255, (av + 255) % 256, "sweep_cla_b255");
            apply("multiplier", av, 255, av * 255, "sweep_mul_b255");
        end

        idle();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
